// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low codes (bit6=a .. bit0=g) and the blank BCD marker.
// The display-side BCD-to-segment decoder uses these same values.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // legal: code is one of 0-9; is_blank: all segments off; bcd: BCD_BLANK unless legal
    typedef struct packed {
        logic       legal;
        logic       is_blank;
        logic [3:0] bcd;
    } seg7_info_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse of the segment decoder: classifies an active-low segment code
// as a digit 0-9, blank, or illegal.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output seg7_info_t o_info
);

    always_comb begin
        o_info.legal    = 1'b1;
        o_info.is_blank = 1'b0;
        o_info.bcd      = BCD_BLANK;
        case (i_seg_n)
            SEG_0:     o_info.bcd = 4'd0;
            SEG_1:     o_info.bcd = 4'd1;
            SEG_2:     o_info.bcd = 4'd2;
            SEG_3:     o_info.bcd = 4'd3;
            SEG_4:     o_info.bcd = 4'd4;
            SEG_5:     o_info.bcd = 4'd5;
            SEG_6:     o_info.bcd = 4'd6;
            SEG_7:     o_info.bcd = 4'd7;
            SEG_8:     o_info.bcd = 4'd8;
            SEG_9:     o_info.bcd = 4'd9;
            SEG_BLANK: begin
                o_info.legal    = 1'b0;
                o_info.is_blank = 1'b1;
            end
            default:   o_info.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reads back a multiplexed active-low 7-segment bus: synchronizes, waits for each pattern
// to settle, then stores the decoded BCD value per digit and flags bad patterns.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
    output logic [4*NUM_DIGITS-1:0]   digits_bcd,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      pattern_err,
    output logic                      frame_done
);

    localparam int W  = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

    logic [W-1:0]              r_sync [SYNC_STAGES];
    logic [W-1:0]              r_prev;
    logic [CW-1:0]             r_cnt;
    logic                      r_armed;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_valid;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic                      r_err;
    logic                      r_frame;

    logic [W-1:0]              w_s;
    logic [NUM_DIGITS-1:0]     w_an;
    logic [NUM_DIGITS-1:0]     w_low;
    logic                      w_same;
    logic                      w_capture;
    logic                      w_one_low;
    logic                      w_seen_full;
    logic                      w_err;
    logic [NUM_DIGITS-1:0]     w_cap_mask;
    logic [NUM_DIGITS-1:0]     w_inv_mask;
    seg7_info_t                w_info;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= {an_n, seg_n};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_an   = w_s[W-1:7];
    assign w_low  = ~w_an;
    assign w_same = (w_s == r_prev);

    // The capture fires on the edge where the counter would reach its last value, once per window.
    assign w_capture = r_armed && w_same && (r_cnt == CNT_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else if (!w_same) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
            if (w_capture) r_armed <= 1'b0;
        end
    end

    seg7_pattern_to_bcd u_decode (
        .i_seg_n (w_s[6:0]),
        .o_info  (w_info)
    );

    assign w_one_low = (w_low != '0) && ((w_low & (w_low - NUM_DIGITS'(1))) == '0);

    always_comb begin
        w_err      = 1'b0;
        w_cap_mask = '0;
        w_inv_mask = '0;
        if (w_capture && (w_low != '0)) begin
            if (!w_one_low) begin
                w_err = 1'b1;
            end else if (w_info.legal || w_info.is_blank) begin
                w_cap_mask = w_low;
            end else begin
                w_err      = 1'b1;
                w_inv_mask = w_low;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= {NUM_DIGITS{BCD_BLANK}};
            r_valid  <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_cap_mask[i]) begin
                    r_digits[4*i +: 4] <= w_info.bcd;
                    r_valid[i]         <= w_info.legal;
                end else if (w_inv_mask[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // A capture landing in the clearing cycle is ORed into the fresh mask so it is not lost.
    assign w_seen_full = &r_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen  <= '0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_seen  <= (w_seen_full ? '0 : r_seen) | w_cap_mask;
            r_err   <= w_err;
            r_frame <= w_seen_full;
        end
    end

    assign digits_bcd  = r_digits;
    assign digit_valid = r_valid;
    assign pattern_err = r_err;
    assign frame_done  = r_frame;

endmodule
